instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 8-bit CPU. It sits directly upstream of the decoder and directly downstream of the 32×8 program ROM. It owns the program counter, drives the ROM address and read strobe, and assembles 1-byte and 3-byte instructions (opcode + 16-bit little-endian operand). Each complete instruction is handed to the decoder over a valid/ready handshake; the execute stage can redirect the PC with a jump.

## Interface
Parameters:
- `PC_W`, 5: program counter / ROM address width (32-byte ROM).
- `RST_PC`, 0: PC value loaded on reset.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `rom_addr` output PC_W: ROM byte address, equal to current PC.
- `rom_read` output 1: ROM read strobe.
- `rom_data` input 8: ROM read data; combinational, valid in the same cycle as `rom_addr`/`rom_read`.
- `ir_opcode` output 8: captured opcode.
- `ir_operand` output 16: captured operand {hi, lo}; 0 for 1-byte instructions.
- `ir_pc` output PC_W: address of the opcode byte of the presented instruction.
- `ir_valid` output 1: instruction presented to the decoder.
- `ir_ready` input 1: decoder accepts the instruction when `ir_valid` is also high.
- `jump_en` input 1: redirect request from execute.
- `jump_target` input PC_W: new PC when `jump_en` is high.
- `ir_illegal` output 1: illegal opcode trap flag (see Configuration).

## Operation
- 3-byte opcodes: 0x01 ldac, 0x02 stac, 0x05 jump, 0x06 jmpz, 0x07 jpnz.
- All other opcodes 0x00–0x0F are 1-byte instructions.
- FSM states:
  - OPC: `rom_read`=1, capture opcode, PC+1. Go to LO for 3-byte opcodes. Otherwise clear the operand, set `ir_valid`, go to HOLD.
  - LO: capture `rom_data` into `ir_operand[7:0]`, PC+1, go to HI.
  - HI: capture `ir_operand[15:8]`, PC+1, set `ir_valid`, go to HOLD.
  - HOLD: `rom_read`=0, all outputs stable. On `ir_valid && ir_ready`, clear `ir_valid` and go to OPC.
- PC increment is modulo 2^PC_W: 31 wraps to 0, including inside a multi-byte instruction.
- Jump: `jump_en` high at an edge, in any state, loads PC from `jump_target`, clears `ir_valid`, clears the partially captured instruction, and goes to OPC. Jump has priority over the handshake; an instruction presented in that cycle is discarded even if `ir_ready` is high.
- `ir_operand` carries the full 16 bits. Truncation to PC_W is the consumer's job.

## Timing
- Reset (`rst_n` low at an edge): PC=RST_PC, state=OPC, `ir_valid`=0, `ir_opcode`=0, `ir_operand`=0, `ir_pc`=0, `ir_illegal`=0. `rom_read` is forced to 0 while `rst_n` is low. Reset mid-instruction abandons it.
- The first ROM read happens in the first cycle with `rst_n` high.
- A 1-byte instruction is valid 1 edge after entering OPC; a 3-byte instruction is valid 3 edges after.
- Minimum issue interval with `ir_ready` held high: 2 cycles for 1-byte instructions, 4 cycles for 3-byte instructions.
- After a jump, `ir_valid` is low for at least 1 cycle. The first instruction at the target is valid 1 or 3 edges after the jump edge.
- `rom_addr` changes only at clock edges.

## Configuration
- `IFETCH_ILLEGAL_TRAP_EN`
- Defined:
  - An opcode > 0x0F is presented as a 1-byte instruction with `ir_illegal`=1.
  - After it is accepted, the FSM stays in HOLD with `ir_valid`=0, `rom_read`=0 and `ir_illegal`=1.
  - Only reset or `jump_en` leaves this trap; both clear `ir_illegal`.
- Undefined: opcodes > 0x0F are treated as 1-byte instructions and `ir_illegal` is tied to 0.

## Test plan
- ROM[0..2]=01,0E,00, `ir_ready`=1, release reset → on the 3rd edge: `ir_valid`=1, `ir_opcode`=0x01, `ir_operand`=0x000E, `ir_pc`=0; next ROM read at address 3.
- ROM[3]=00, ROM[4]=08 → NOP valid with `ir_pc`=3, then ADD valid with `ir_pc`=4, 2 cycles apart, `ir_operand`=0.
- Hold `ir_ready`=0 for 5 cycles while a 3-byte instruction is valid → outputs stable and `rom_read`=0; accepted on the cycle `ir_ready` rises.
- Assert `jump_en`, `jump_target`=16 during LO → no `ir_valid` for the partial instruction; next `ir_pc`=16.
- Opcode 0x07 at address 30 → operand bytes read from 31 then 0; next fetch at address 1.
- With `IFETCH_ILLEGAL_TRAP_EN`, opcode 0xFF at address 5 → `ir_illegal`=1 and no further ROM reads until `jump_en`. Without the macro → `ir_illegal`=0 and fetch continues at address 6.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM, decoder and jump signals of the instruction fetch stage
interface instr_fetch_if #(
    parameter int PC_W = 5
);
    logic [PC_W-1:0] rom_addr;
    logic            rom_read;
    logic [7:0]      rom_data;
    logic [7:0]      ir_opcode;
    logic [15:0]     ir_operand;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;
    logic            jump_en;
    logic [PC_W-1:0] jump_target;
    logic            ir_illegal;

    modport master (
        output rom_addr, rom_read, ir_opcode, ir_operand, ir_pc, ir_valid, ir_illegal,
        input  rom_data, ir_ready, jump_en, jump_target
    );

    modport slave (
        input  rom_addr, rom_read, ir_opcode, ir_operand, ir_pc, ir_valid, ir_illegal,
        output rom_data, ir_ready, jump_en, jump_target
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, ROM read and 1/3-byte instruction assembly; IFETCH_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module instr_fetch #(
    parameter int              PC_W   = 5,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam logic [1:0] S_OPC  = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      opcode;
    logic [15:0]     operand;
    logic [PC_W-1:0] op_pc;
    logic            valid;
    logic            illegal;
    logic            is_long;
    logic            is_illegal;

    always_comb begin
        is_long = 1'b0;
        case (bus.rom_data)
            8'h01, 8'h02, 8'h05, 8'h06, 8'h07: is_long = 1'b1;
            default:                           is_long = 1'b0;
        endcase
    end

`ifdef IFETCH_ILLEGAL_TRAP_EN
    assign is_illegal = (bus.rom_data > 8'h0F);
`else
    assign is_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_OPC;
            pc      <= RST_PC;
            opcode  <= '0;
            operand <= '0;
            op_pc   <= '0;
            valid   <= 1'b0;
            illegal <= 1'b0;
        end else if (bus.jump_en) begin
            // Redirect wins over everything, including a same-cycle handshake.
            state   <= S_OPC;
            pc      <= bus.jump_target;
            opcode  <= '0;
            operand <= '0;
            valid   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_OPC: begin
                    opcode <= bus.rom_data;
                    op_pc  <= pc;
                    pc     <= pc + 1'b1;
                    operand <= '0;
                    if (is_long && !is_illegal) begin
                        state <= S_LO;
                    end else begin
                        valid   <= 1'b1;
                        illegal <= is_illegal;
                        state   <= S_HOLD;
                    end
                end
                S_LO: begin
                    operand[7:0] <= bus.rom_data;
                    pc           <= pc + 1'b1;
                    state        <= S_HI;
                end
                S_HI: begin
                    operand[15:8] <= bus.rom_data;
                    pc            <= pc + 1'b1;
                    valid         <= 1'b1;
                    state         <= S_HOLD;
                end
                default: begin
                    // A trapped opcode parks here once accepted until reset or jump.
                    if (valid && bus.ir_ready) begin
                        valid <= 1'b0;
                        if (!illegal) state <= S_OPC;
                    end
                end
            endcase
        end
    end

    assign bus.rom_addr   = pc;
    assign bus.rom_read   = rst_n && (state != S_HOLD);
    assign bus.ir_opcode  = opcode;
    assign bus.ir_operand = operand;
    assign bus.ir_pc      = op_pc;
    assign bus.ir_valid   = valid;
    assign bus.ir_illegal = illegal;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed test of instr_fetch against a 32-byte ROM model
module tb_instr_fetch;
    localparam int PC_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] rom [32];
    int tests = 0;
    int fails = 0;

    instr_fetch_if #(.PC_W(PC_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .RST_PC(5'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h01; rom[1] = 8'h0E; rom[2] = 8'h00;
        rom[3] = 8'h00; rom[4] = 8'h08; rom[5] = 8'hFF;
        rom[6] = 8'h02; rom[7] = 8'h34; rom[8] = 8'h12;
        rom[9] = 8'h01; rom[10] = 8'h55; rom[11] = 8'h66;
        rom[16] = 8'h03;
        rom[30] = 8'h07; rom[31] = 8'hAA;

        rst_n = 1'b0;
        bus.ir_ready = 1'b1;
        bus.jump_en = 1'b0;
        bus.jump_target = '0;
        tick(); tick();
        check("rst_valid",   bus.ir_valid,   0);
        check("rst_opcode",  bus.ir_opcode,  0);
        check("rst_operand", bus.ir_operand, 0);
        check("rst_pc",      bus.ir_pc,      0);
        check("rst_illegal", bus.ir_illegal, 0);
        check("rst_read",    bus.rom_read,   0);
        check("rst_addr",    bus.rom_addr,   0);

        rst_n = 1'b1;
        #1;
        check("first_read", bus.rom_read, 1);
        tick(); check("ldac_e1_valid", bus.ir_valid, 0);
        tick(); check("ldac_e2_valid", bus.ir_valid, 0);
        tick();
        check("ldac_valid",   bus.ir_valid,   1);
        check("ldac_opcode",  bus.ir_opcode,  8'h01);
        check("ldac_operand", bus.ir_operand, 16'h000E);
        check("ldac_pc",      bus.ir_pc,      0);
        check("ldac_noread",  bus.rom_read,   0);
        tick();
        check("after_ldac_addr", bus.rom_addr, 3);
        check("after_ldac_read", bus.rom_read, 1);
        check("after_ldac_valid", bus.ir_valid, 0);
        tick();
        check("nop_valid",   bus.ir_valid,   1);
        check("nop_pc",      bus.ir_pc,      3);
        check("nop_operand", bus.ir_operand, 0);
        tick(); check("gap_valid", bus.ir_valid, 0);
        tick();
        check("add_valid",   bus.ir_valid,   1);
        check("add_opcode",  bus.ir_opcode,  8'h08);
        check("add_pc",      bus.ir_pc,      4);
        check("add_operand", bus.ir_operand, 0);
        tick(); check("ff_addr", bus.rom_addr, 5);
        tick();
        check("ff_valid",  bus.ir_valid,  1);
        check("ff_opcode", bus.ir_opcode, 8'hFF);
        check("ff_pc",     bus.ir_pc,     5);
`ifdef IFETCH_ILLEGAL_TRAP_EN
        check("ff_illegal", bus.ir_illegal, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_valid",   bus.ir_valid,   0);
            check("trap_read",    bus.rom_read,   0);
            check("trap_illegal", bus.ir_illegal, 1);
        end
        bus.jump_en = 1'b1; bus.jump_target = 5'd6;
        tick();
        bus.jump_en = 1'b0;
        check("trap_exit_illegal", bus.ir_illegal, 0);
`else
        check("ff_illegal", bus.ir_illegal, 0);
        tick();
`endif
        check("stac_addr", bus.rom_addr, 6);
        check("stac_read", bus.rom_read, 1);

        bus.ir_ready = 1'b0;
        tick(); tick(); tick();
        check("stac_valid",   bus.ir_valid,   1);
        check("stac_operand", bus.ir_operand, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid",   bus.ir_valid,   1);
            check("stall_opcode",  bus.ir_opcode,  8'h02);
            check("stall_operand", bus.ir_operand, 16'h1234);
            check("stall_pc",      bus.ir_pc,      6);
            check("stall_read",    bus.rom_read,   0);
            check("stall_addr",    bus.rom_addr,   9);
        end
        bus.ir_ready = 1'b1;
        tick();
        check("accept_valid", bus.ir_valid, 0);
        check("accept_read",  bus.rom_read, 1);
        check("accept_addr",  bus.rom_addr, 9);

        tick();
        check("lo_addr", bus.rom_addr, 10);
        bus.jump_en = 1'b1; bus.jump_target = 5'd16;
        tick();
        bus.jump_en = 1'b0;
        check("jmp_lo_valid", bus.ir_valid, 0);
        check("jmp_lo_addr",  bus.rom_addr, 16);
        tick();
        check("tgt_valid",  bus.ir_valid,  1);
        check("tgt_pc",     bus.ir_pc,     16);
        check("tgt_opcode", bus.ir_opcode, 8'h03);
        tick();
        check("tgt_next_addr", bus.rom_addr, 17);

        bus.jump_en = 1'b1; bus.jump_target = 5'd30;
        tick();
        bus.jump_en = 1'b0;
        check("wrap_addr30", bus.rom_addr, 30);
        tick(); check("wrap_addr31", bus.rom_addr, 31);
        tick(); check("wrap_addr0",  bus.rom_addr, 0);
        tick();
        check("jpnz_valid",   bus.ir_valid,   1);
        check("jpnz_opcode",  bus.ir_opcode,  8'h07);
        check("jpnz_operand", bus.ir_operand, 16'h01AA);
        check("jpnz_pc",      bus.ir_pc,      30);
        tick();
        check("wrap_next_addr", bus.rom_addr, 1);
        check("wrap_next_read", bus.rom_read, 1);

        tick();
        check("prio_valid", bus.ir_valid, 1);
        check("prio_pc",    bus.ir_pc,    1);
        bus.jump_en = 1'b1; bus.jump_target = 5'd4;
        tick();
        bus.jump_en = 1'b0;
        check("prio_drop_valid", bus.ir_valid, 0);
        check("prio_addr",       bus.rom_addr, 4);
        tick();
        check("prio_tgt_valid", bus.ir_valid, 1);
        check("prio_tgt_pc",    bus.ir_pc,    4);

        rst_n = 1'b0;
        tick();
        check("rst2_valid", bus.ir_valid, 0);
        check("rst2_addr",  bus.rom_addr, 0);
        check("rst2_read",  bus.rom_read, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
